// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the instruction register.
// Holds the PC, reads one word per fetch from instruction memory over a
// req/ack handshake, and hands the word to the IR with a one-cycle load pulse.
module fetch_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic                  jmp,
  input  logic [ADDR_WIDTH-1:0] jmp_addr,
  input  logic                  stall,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  ir_en,
  output logic [DATA_WIDTH-1:0] ir_d,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  // State, PC and fetched-word registers; reset also clears the IR word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      word_q  <= word_d;
    end
  end

  // Next-state logic: a jump always wins over fetching, acks and stalls.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    word_d  = word_q;
    unique case (state_q)
      S_IDLE: begin
        if (jmp) begin
          pc_d = jmp_addr;
        end else if (fetch_req) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (jmp) begin
          // Abort: an ack arriving in the same cycle is thrown away.
          pc_d    = jmp_addr;
          state_d = S_IDLE;
        end else if (mem_ack) begin
          word_d  = mem_data;
          pc_d    = pc_q + PC_ONE;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (jmp) begin
          // Unstalled word still goes out via ir_en; a stalled one is dropped.
          pc_d    = jmp_addr;
          state_d = S_IDLE;
        end else if (!stall) begin
          state_d = fetch_req ? S_REQ : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_rd   = (state_q == S_REQ);
  assign mem_addr = pc_q;
  assign ir_en    = (state_q == S_LOAD) && !stall;
  assign ir_d     = word_q;
  assign pc       = pc_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model (outstanding read / word waiting for the IR).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic        jmp = 1'b0;
  logic [15:0] jmp_addr = 16'h0;
  logic        stall = 1'b0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = 16'h0;
  logic        ir_en;
  logic [15:0] ir_d;
  logic [15:0] pc;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: PC, IR contents, whether a read is outstanding and
  // whether a fetched word is waiting to be handed to the IR.
  logic [15:0] m_pc = 16'h0;
  logic [15:0] m_ir = 16'h0;
  bit          m_reading = 1'b0;
  bit          m_have = 1'b0;

  fetch_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .jmp(jmp), .jmp_addr(jmp_addr),
    .stall(stall), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .ir_en(ir_en), .ir_d(ir_d), .pc(pc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, updating the model from the inputs seen there.
  task automatic tick();
    if (rst) begin
      m_pc = 16'h0000; m_ir = 16'h0000; m_reading = 0; m_have = 0;
    end else if (m_reading) begin
      if (jmp) begin
        m_pc = jmp_addr; m_reading = 0;
      end else if (mem_ack) begin
        m_ir = mem_data; m_pc = m_pc + 16'd1; m_reading = 0; m_have = 1;
      end
    end else if (m_have) begin
      if (jmp) begin
        m_pc = jmp_addr; m_have = 0;
      end else if (!stall) begin
        m_have = 0; m_reading = fetch_req;
      end
    end else begin
      if (jmp) m_pc = jmp_addr;
      else if (fetch_req) m_reading = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; fetch_req = 0; jmp = 0; jmp_addr = 16'h0; stall = 0; mem_ack = 0; mem_data = 16'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; tick(); rst = 0; #1;
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", pc); end
    n_checks++; if (ir_d !== 16'h0000) begin n_fail++; $display("FAIL reset_ir_d: got %h want 0000", ir_d); end
    n_checks++; if (ir_en !== 1'b0) begin n_fail++; $display("FAIL reset_ir_en: got %b want 0", ir_en); end
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_fetch();
    fetch_req = 1; #1;
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL single_latency: mem_rd got %b want 0", mem_rd); end
    tick(); fetch_req = 0; #1;
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL single_req: mem_rd %b addr %h want 1 0000", mem_rd, mem_addr); end
    tick(); tick();
    mem_ack = 1; mem_data = 16'h00FF; #1;
    n_checks++; if (mem_rd !== 1'b1 || ir_en !== 1'b0) begin n_fail++; $display("FAIL single_wait: mem_rd %b ir_en %b want 1 0", mem_rd, ir_en); end
    tick(); mem_ack = 0; #1;
    n_checks++; if (ir_en !== 1'b1 || ir_d !== 16'h00FF || pc !== 16'h0001) begin n_fail++; $display("FAIL single_load: ir_en %b ir_d %h pc %h want 1 00ff 0001", ir_en, ir_d, pc); end
    tick(); #1;
    n_checks++; if (ir_en !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL single_done: ir_en %b busy %b mem_rd %b want 0 0 0", ir_en, busy, mem_rd); end
  endtask

  task automatic test_back_to_back();
    rst = 1; tick(); rst = 0;
    fetch_req = 1; tick(); #1;
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL b2b_addr0: mem_rd %b addr %h want 1 0000", mem_rd, mem_addr); end
    mem_ack = 1; mem_data = 16'h1111; tick(); mem_ack = 0; #1;
    n_checks++; if (ir_en !== 1'b1 || ir_d !== 16'h1111) begin n_fail++; $display("FAIL b2b_word0: ir_en %b ir_d %h want 1 1111", ir_en, ir_d); end
    tick(); #1;
    n_checks++; if (ir_en !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0001) begin n_fail++; $display("FAIL b2b_addr1: ir_en %b mem_rd %b addr %h want 0 1 0001", ir_en, mem_rd, mem_addr); end
    mem_ack = 1; mem_data = 16'h2222; tick(); mem_ack = 0; fetch_req = 0; #1;
    n_checks++; if (ir_en !== 1'b1 || ir_d !== 16'h2222 || pc !== 16'h0002) begin n_fail++; $display("FAIL b2b_word1: ir_en %b ir_d %h pc %h want 1 2222 0002", ir_en, ir_d, pc); end
    tick();
  endtask

  task automatic test_jmp_abort();
    fetch_req = 1; tick(); fetch_req = 0;
    jmp = 1; jmp_addr = 16'h0040; mem_ack = 1; mem_data = 16'hDEAD; tick();
    jmp = 0; mem_ack = 0; #1;
    n_checks++; if (ir_en !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: ir_en %b mem_rd %b busy %b want 0 0 0", ir_en, mem_rd, busy); end
    n_checks++; if (ir_d !== 16'h2222 || pc !== 16'h0040) begin n_fail++; $display("FAIL abort_regs: ir_d %h pc %h want 2222 0040", ir_d, pc); end
    tick(); #1;
    n_checks++; if (ir_en !== 1'b0) begin n_fail++; $display("FAIL abort_nopulse: ir_en got %b want 0", ir_en); end
    fetch_req = 1; tick(); fetch_req = 0; #1;
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0040) begin n_fail++; $display("FAIL abort_refetch: mem_rd %b addr %h want 1 0040", mem_rd, mem_addr); end
    mem_ack = 1; mem_data = 16'h1234; tick(); mem_ack = 0; tick();
  endtask

  task automatic test_stall();
    fetch_req = 1; tick(); fetch_req = 0;
    mem_ack = 1; mem_data = 16'hABCD; stall = 1; tick(); mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (ir_en !== 1'b0 || ir_d !== 16'hABCD || busy !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d: ir_en %b ir_d %h busy %b want 0 abcd 1", i, ir_en, ir_d, busy); end
      if (i < 2) tick();
    end
    stall = 0; #1;
    n_checks++; if (ir_en !== 1'b1 || ir_d !== 16'hABCD) begin n_fail++; $display("FAIL stall_release: ir_en %b ir_d %h want 1 abcd", ir_en, ir_d); end
    tick(); #1;
    n_checks++; if (ir_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stall_after: ir_en %b busy %b want 0 0", ir_en, busy); end
  endtask

  task automatic test_wrap();
    jmp = 1; jmp_addr = 16'hFFFF; tick(); jmp = 0; #1;
    n_checks++; if (pc !== 16'hFFFF || busy !== 1'b0) begin n_fail++; $display("FAIL wrap_jmp: pc %h busy %b want ffff 0", pc, busy); end
    fetch_req = 1; tick(); fetch_req = 0; #1;
    n_checks++; if (mem_addr !== 16'hFFFF || mem_rd !== 1'b1) begin n_fail++; $display("FAIL wrap_addr: addr %h mem_rd %b want ffff 1", mem_addr, mem_rd); end
    mem_ack = 1; mem_data = 16'h7777; tick(); mem_ack = 0; #1;
    n_checks++; if (pc !== 16'h0000 || ir_d !== 16'h7777) begin n_fail++; $display("FAIL wrap_pc: pc %h ir_d %h want 0000 7777", pc, ir_d); end
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    jmp = 1; jmp_addr = 16'h0123; tick(); jmp = 0;
    fetch_req = 1; tick(); #1;
    n_checks++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL rstmid_req: mem_rd got %b want 1", mem_rd); end
    rst = 1; jmp = 1; jmp_addr = 16'h0077; mem_ack = 1; mem_data = 16'h5555; tick();
    clear_inputs(); #1;
    n_checks++; if (mem_rd !== 1'b0 || busy !== 1'b0 || ir_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: mem_rd %b busy %b ir_en %b want 0 0 0", mem_rd, busy, ir_en); end
    n_checks++; if (pc !== 16'h0000 || ir_d !== 16'h0000) begin n_fail++; $display("FAIL rstmid_regs: pc %h ir_d %h want 0000 0000", pc, ir_d); end
  endtask

  task automatic test_random();
    clear_inputs();
    rst = 1; tick(); rst = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst       = ($urandom_range(0, 99) == 0);
      jmp       = ($urandom_range(0, 7) == 0);
      jmp_addr  = 16'($urandom);
      if ($urandom_range(0, 15) == 0) jmp_addr = 16'hFFFF;
      fetch_req = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 2) == 0);
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_data  = 16'($urandom);
      #1;
      n_checks++;
      if (mem_rd !== m_reading || ir_en !== (m_have && !stall) || busy !== (m_reading || m_have) ||
          pc !== m_pc || ir_d !== m_ir || mem_addr !== m_pc) begin
        n_fail++;
        $display("FAIL random cyc %0d: rd %b en %b busy %b pc %h ir %h addr %h want rd %b en %b busy %b pc %h ir %h",
                 cyc, mem_rd, ir_en, busy, pc, ir_d, mem_addr, m_reading, (m_have && !stall),
                 (m_reading || m_have), m_pc, m_ir);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_jmp_abort();
    test_stall();
    test_wrap();
    test_reset_mid_fetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
